// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; non-MUL ops complete in one cycle, MUL in WIDTH+1.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHAMT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUCon,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_slt;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_acc_next;
    logic [CW-1:0]    w_cnt_next;

    function automatic logic f_add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic f_sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_mul   = (ALUCon == OP_MUL);
    assign w_slt      = ($signed(DataA) < $signed(DataB));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
    assign w_cnt_next = r_cnt - CW'(1);

    // Single-cycle ALU result and overflow flag for the non-MUL opcodes
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        w_alu_ovf = 1'b0;
        case (ALUCon)
            OP_ADD: begin
                w_alu_res = DataA + DataB;
                w_alu_ovf = f_add_ovf(DataA[WIDTH-1], DataB[WIDTH-1], w_alu_res[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = DataA - DataB;
                w_alu_ovf = f_sub_ovf(DataA[WIDTH-1], DataB[WIDTH-1], w_alu_res[WIDTH-1]);
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SHL:  w_alu_res = DataB << SHAMT;
            OP_AND:  w_alu_res = DataA & DataB;
            OP_OR:   w_alu_res = DataA | DataB;
            OP_XOR:  w_alu_res = DataA ^ DataB;
            default: w_alu_res = {WIDTH{1'b0}};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; MUL leaves on the step that decrements the counter to zero
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? S_MUL : S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (w_cnt_next == {CW{1'b0}}) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_MUL;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result/flag registers and the shift-add multiplier datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_acc    <= {WIDTH{1'b0}};
                        r_mcand  <= DataA;
                        r_mplier <= DataB;
                        r_cnt    <= CW'(WIDTH);
                    end else if (w_accept) begin
                        r_result <= w_alu_res;
                        r_zero   <= (w_alu_res == {WIDTH{1'b0}});
                        r_ovf    <= w_alu_ovf;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= w_cnt_next;
                    if (w_cnt_next == {CW{1'b0}}) begin
                        r_result <= w_acc_next;
                        r_zero   <= (w_acc_next == {WIDTH{1'b0}});
                        r_ovf    <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign Result = r_result;
    assign zero   = r_zero;
    assign ovf    = r_ovf;

endmodule
